// File: rtl/bcd_display_driver_if.sv
// Value/display bundle for bcd_display_driver.
// master: the producer of values and consumer of the display outputs.
// slave:  the driver itself.
interface bcd_display_driver_if;
  logic [13:0] value;
  logic        value_valid;
  logic        value_ready;
  logic [15:0] bcd;
  logic        ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (
    output value, value_valid,
    input  value_ready, bcd, ovf, seg, an
  );

  modport slave (
    input  value, value_valid,
    output value_ready, bcd, ovf, seg, an
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (serial double-dabble, 14 cycles per value)
// feeding a 4-digit multiplexed 7-segment display with optional
// leading-zero blanking and an overflow dash pattern.
module bcd_display_driver #(
  parameter int CLK_DIV = 50000,  // clk cycles per digit-scan step, >= 2
  parameter int LZB     = 1       // 1 = blank leading zeros, 0 = show them
) (
  input logic              clk,
  input logic              rst,
  bcd_display_driver_if.slave bus
);

  localparam int          PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [3:0]  SHIFTS    = 4'd14;

  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Converter state
  state_t      state;
  logic [13:0] shift_val;    // remaining binary bits, MSB shifted out first
  logic [15:0] scratch;      // BCD accumulator
  logic [3:0]  count;        // SHIFT cycles remaining
  logic        ovf_pending;  // latched value was above 9999
  logic [15:0] bcd_reg;
  logic        ovf_reg;

  // Display state
  logic [PW-1:0] presc;
  logic [1:0]    index;
  logic [6:0]    seg_reg;
  logic [3:0]    an_reg;

  // Double-dabble datapath
  logic [15:0] scratch_adj;
  logic [30:0] dd_next;
  logic        overflow_now;

  // Display datapath
  logic [4:0]  zero_from;    // zero_from[i]: digit i and everything above are 0
  logic [6:0]  glyph [4];

  // Decode one BCD digit to its active-low gfedcba pattern.
  // Codes 10..15 cannot come out of the converter and show blank.
  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch[gi*4 +: 4] >= 4'd5)
                                      ? scratch[gi*4 +: 4] + 4'd3
                                      : scratch[gi*4 +: 4];
    end
  endgenerate

  // One left shift of {scratch, value}; bit 30 is a carry out of the
  // thousands digit, which can only happen for values above 9999.
  assign dd_next      = {scratch_adj, shift_val, 1'b0};
  assign overflow_now = ovf_pending | dd_next[30];

  // Converter FSM: accept in IDLE, run 14 shift steps, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift_val   <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.value_valid) begin
            shift_val   <= bus.value;
            scratch     <= '0;
            count       <= SHIFTS;
            ovf_pending <= (bus.value > 14'd9999);
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= dd_next[29:14];
          shift_val <= dd_next[13:0];
          count     <= count - 4'd1;
          if (count == 4'd1) begin
            bcd_reg <= overflow_now ? 16'h0000 : dd_next[29:14];
            ovf_reg <= overflow_now;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is forced low while reset is held so no value is taken then.
  assign bus.value_ready = (state == IDLE) && !rst;
  assign bus.bcd         = bcd_reg;
  assign bus.ovf         = ovf_reg;

  // Leading-zero chain from the most significant digit downward.
  assign zero_from[4] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign zero_from[gi] = (bcd_reg[gi*4 +: 4] == 4'd0) && zero_from[gi+1];

      if (gi == 0) begin : g_ones
        // The ones digit is never blanked so zero reads as "0".
        assign glyph[gi] = ovf_reg ? GLYPH_DASH : glyph_of(bcd_reg[3:0]);
      end else begin : g_upper
        logic blank_lz;
        assign blank_lz  = (LZB != 0) && zero_from[gi];
        assign glyph[gi] = ovf_reg  ? GLYPH_DASH  :
                           blank_lz ? GLYPH_BLANK :
                           glyph_of(bcd_reg[gi*4 +: 4]);
      end
    end
  endgenerate

  // Scan prescaler; on each wrap show the current digit, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      index   <= 2'd0;
      seg_reg <= GLYPH_BLANK;
      an_reg  <= 4'hF;
    end else if (presc == PRESC_MAX) begin
      presc   <= '0;
      index   <= index + 2'd1;
      an_reg  <= ~(4'b0001 << index);
      seg_reg <= glyph[index];
    end else begin
      presc   <= presc + 1'b1;
    end
  end

  assign bus.seg = seg_reg;
  assign bus.an  = an_reg;

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 Parameter: CLK_DIV, default 50000, clk cycles per digit-scan step (minimum 2).
REQ-002 Parameter: LZB, default 1, leading-zero blanking enable (1 = blank, 0 = show zeros).
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: value  input  14  unsigned binary count to display; legal display range 0..9999.
REQ-006 Port: value_valid  input  1  value is presented for conversion this cycle.
REQ-007 Port: value_ready  output  1  converter idle; a value is accepted when value_valid and value_ready are both 1.
REQ-008 Port: bcd  output  16  last converted digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 Port: ovf  output  1  last accepted value exceeded 9999.
REQ-010 Port: seg  output  7  active-low segments, bit order gfedcba (seg[0] = a).
REQ-011 Port: an  output  4  active-low digit enables; an[0] = ones (rightmost), an[3] = thousands.

Function
REQ-012 Converter FSM states: IDLE and SHIFT; value_ready SHALL equal 1 only in IDLE and when rst = 0.
REQ-013 On accept in IDLE: latch value, clear the 16-bit BCD scratch register, load shift count 14, enter SHIFT.
REQ-014 In SHIFT, each cycle: add 3 to every scratch nibble >= 5, then shift {scratch, value} left 1 (double-dabble).
REQ-015 Exactly 14 SHIFT cycles. The edge ending the 14th SHIFT cycle updates bcd and ovf and returns to IDLE. value_ready is low for exactly 14 cycles after the accept edge.
REQ-016 value_valid is ignored outside IDLE. Input changes during SHIFT do not affect the result.
REQ-017 Overflow (latched value > 9999): after the same 14-cycle latency, bcd = 16'h0000 and ovf = 1. Otherwise ovf = 0.
REQ-018 Scan prescaler counts 0..CLK_DIV-1 and wraps. At wrap, the 2-bit digit index advances 0->1->2->3->0.
REQ-019 an SHALL be registered, with exactly one bit low: an[index].
REQ-020 seg SHALL be registered from the same index, so seg and an update on the same edge.
REQ-021 Digit glyphs (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, dash=3F, blank=7F.
REQ-022 When ovf = 1, every digit SHALL show dash; blanking is not applied.
REQ-023 When LZB = 1 and ovf = 0, a digit SHALL show blank if it and all more-significant digits are 0; the ones digit is never blanked, so 0 shows as a single "0".
REQ-024 Display always reflects the current bcd/ovf registers. A conversion completing mid-scan takes effect on the next seg/an update.
REQ-025 Nibbles outside 0..9 (unreachable) SHALL display blank.

Reset
REQ-026 While rst = 1, at each clk edge the outputs SHALL be: state IDLE, value_ready = 0, bcd = 16'h0000, ovf = 0, seg = 7'h7F, an = 4'hF, prescaler = 0, index = 0.
REQ-027 rst asserted during SHIFT SHALL abort the conversion with no bcd update.
REQ-028 value_ready = 1 in the first cycle after rst deasserts. The first an assertion (an = 4'hE) occurs on the edge where the prescaler first wraps.

Verification (CLK_DIV = 4 unless stated)
REQ-029 Accept value = 1234 -> value_ready low 14 cycles, then bcd = 16'h1234, ovf = 0; scan shows an=E/seg=19, an=D/seg=30, an=B/seg=24, an=7/seg=79.
REQ-030 Accept value = 9999, then 0, then 10000 -> bcd = 16'h9999; then 16'h0000 with only an[0] showing seg = 40 and digits 1..3 showing 7F (LZB = 1); then ovf = 1 with all four digits = 3F.
REQ-031 Accept value = 7, change value to 5000 with value_valid = 1 during SHIFT -> bcd = 16'h0007; 5000 is accepted only after value_ready returns to 1.
REQ-032 Assert rst at SHIFT cycle 6 of value = 4321 -> bcd = 0, an = F, seg = 7F; after release, value_ready = 1 on the next cycle.
REQ-033 LZB = 0, value = 42 -> digits show 40, 40, 19, 24 for an[3..0].
REQ-034 Index wrap -> an sequence E, D, B, 7, E, with each step exactly CLK_DIV cycles apart.
